// File: rtl/btn_debouncer.sv
// Per-channel synchronizer plus debounce FSM for raw push-button pins.
// Emits debounced level, press/release pulses and a sticky pending flag.
module btn_debouncer #(
   parameter int NUM_BTNS        = 5,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_raw,
   input  logic [NUM_BTNS-1:0] clr,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_press,
   output logic [NUM_BTNS-1:0] btn_release,
   output logic [NUM_BTNS-1:0] btn_pending
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW,
      RISE_WAIT,
      HIGH,
      FALL_WAIT
   } state_t;

   logic [NUM_BTNS-1:0] s1;
   logic [NUM_BTNS-1:0] s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      state_t        state;
      state_t        state_n;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_n;
      logic          press_n;
      logic          rel_n;
      logic          press_q;
      logic          rel_q;
      logic          pend_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            state   <= LOW;
            cnt     <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            press_q <= press_n;
            rel_q   <= rel_n;
            // a press landing on a clear edge wins
            pend_q  <= press_n | (pend_q & ~clr[i]);
         end
      end

      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         press_n = 1'b0;
         rel_n   = 1'b0;
         unique case (state)
            LOW: begin
               if (s2[i]) begin
                  state_n = RISE_WAIT;
                  cnt_n   = CW'(1);
               end else begin
                  cnt_n = '0;
               end
            end
            RISE_WAIT: begin
               if (!s2[i]) begin
                  state_n = LOW;
                  cnt_n   = '0;
               end else if (cnt == LAST) begin
                  state_n = HIGH;
                  cnt_n   = '0;
                  press_n = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            HIGH: begin
               if (!s2[i]) begin
                  state_n = FALL_WAIT;
                  cnt_n   = CW'(1);
               end else begin
                  cnt_n = '0;
               end
            end
            FALL_WAIT: begin
               if (s2[i]) begin
                  state_n = HIGH;
                  cnt_n   = '0;
               end else if (cnt == LAST) begin
                  state_n = LOW;
                  cnt_n   = '0;
                  rel_n   = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = LOW;
               cnt_n   = '0;
            end
         endcase
      end

      assign btn_level[i]   = (state == HIGH) || (state == FALL_WAIT);
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
      assign btn_pending[i] = pend_q;
   end

endmodule

// File: tb/tb_btn_debouncer.sv
// Randomized and directed bench for btn_debouncer, with a sliding-window
// reference model of the synchronizer and debounce rules.
module tb_btn_debouncer;

   localparam int NB = 5;
   localparam int D  = 4;
   localparam logic [D-1:0] ONES = '1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] clr = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic [NB-1:0] btn_pending;

   btn_debouncer #(
      .NUM_BTNS(NB),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .clr(clr),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_pending(btn_pending)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: synchronizer copy plus a window of the last D synchronized samples
   logic [NB-1:0] ms1 = '0, ms2 = '0;
   logic [NB-1:0] mlevel = '0, mpress = '0, mrel = '0, mpend = '0;
   logic [D-1:0]  hw [NB];
   int            hn [NB];

   task automatic model_edge();
      logic [NB-1:0] np, nr;
      logic          flip;
      np = '0;
      nr = '0;
      if (reset) begin
         ms1 = '0; ms2 = '0;
         mlevel = '0; mpress = '0; mrel = '0; mpend = '0;
         for (int i = 0; i < NB; i++) begin
            hw[i] = '0;
            hn[i] = 0;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            hw[i] = {hw[i][D-2:0], ms2[i]};
            if (hn[i] < D) hn[i]++;
            flip = (hn[i] >= D) && (hw[i] == (mlevel[i] ? '0 : ONES));
            np[i] = flip && !mlevel[i];
            nr[i] = flip && mlevel[i];
            if (flip) mlevel[i] = ~mlevel[i];
         end
         mpress = np;
         mrel   = nr;
         mpend  = (mpend & ~clr) | np;
         ms2    = ms1;
         ms1    = btn_raw;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      int rise, np;
      reset = 1'b1;
      btn_raw = '1;
      clr = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {btn_level, btn_press, btn_release, btn_pending});
         end
      end
      reset = 1'b0;
      btn_raw = 5'b00001;
      rise = -1;
      np = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !==
             {mlevel, mpress, mrel, mpend}) begin
            n_err++;
            $display("FAIL reset_model got=%h exp=%h",
                     {btn_level, btn_press, btn_release, btn_pending},
                     {mlevel, mpress, mrel, mpend});
         end
         if (btn_level[0] && rise < 0) rise = k;
         if (btn_press[0]) np++;
      end
      n_cmp++;
      if (rise !== 6) begin
         n_err++;
         $display("FAIL reset_rise_edge got=%0d exp=6", rise);
      end
      n_cmp++;
      if (np !== 1) begin
         n_err++;
         $display("FAIL reset_press_count got=%0d exp=1", np);
      end
   endtask

   task automatic test_press_release();
      int rise, fall, np, nr;
      reset = 1'b1;
      btn_raw = '0;
      step();
      step();
      reset = 1'b0;
      rise = -1; fall = -1; np = 0; nr = 0;
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 21) btn_raw[0] = 1'b0;
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !==
             {mlevel, mpress, mrel, mpend}) begin
            n_err++;
            $display("FAIL pr_model got=%h exp=%h",
                     {btn_level, btn_press, btn_release, btn_pending},
                     {mlevel, mpress, mrel, mpend});
         end
         if (btn_level[0] && rise < 0) rise = k;
         if (!btn_level[0] && rise > 0 && fall < 0) fall = k - 20;
         if (btn_press[0]) np++;
         if (btn_release[0]) nr++;
         if (rise > 0) begin
            n_cmp++;
            if (btn_pending[0] !== 1'b1) begin
               n_err++;
               $display("FAIL pr_pending k=%0d got=%b exp=1", k, btn_pending[0]);
            end
         end
      end
      n_cmp++;
      if (rise !== 6 || fall !== 6) begin
         n_err++;
         $display("FAIL pr_latency got=%0d/%0d exp=6/6", rise, fall);
      end
      n_cmp++;
      if (np !== 1 || nr !== 1) begin
         n_err++;
         $display("FAIL pr_pulses got=%0d/%0d exp=1/1", np, nr);
      end
   endtask

   task automatic test_bounce();
      logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int rise, np;
      for (int i = 0; i < 5; i++) begin
         btn_raw[1] = pat[i];
         step();
         n_cmp++;
         if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_quiet i=%0d got=%b%b exp=00",
                     i, btn_level[1], btn_press[1]);
         end
      end
      btn_raw[1] = 1'b1;
      rise = -1;
      np = 0;
      for (int k = 1; k <= 15; k++) begin
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !==
             {mlevel, mpress, mrel, mpend}) begin
            n_err++;
            $display("FAIL bounce_model got=%h exp=%h",
                     {btn_level, btn_press, btn_release, btn_pending},
                     {mlevel, mpress, mrel, mpend});
         end
         if (btn_level[1] && rise < 0) rise = k;
         if (btn_press[1]) np++;
      end
      n_cmp++;
      if (rise !== 6 || np !== 1) begin
         n_err++;
         $display("FAIL bounce_rise got=%0d/%0d exp=6/1", rise, np);
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 15; k++) begin
         btn_raw[2] = (k < 3);
         step();
         n_cmp++;
         if ({btn_level[2], btn_press[2], btn_pending[2]} !== 3'b000) begin
            n_err++;
            $display("FAIL glitch k=%0d got=%b exp=000", k,
                     {btn_level[2], btn_press[2], btn_pending[2]});
         end
      end
   endtask

   task automatic test_pending_clear();
      bit seen;
      reset = 1'b1;
      btn_raw = '0;
      clr = '0;
      step();
      reset = 1'b0;
      btn_raw[4] = 1'b1;
      for (int k = 0; k < 10; k++) step();
      btn_raw[0] = 1'b1;
      clr[0] = 1'b1;
      seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         step();
         if (btn_press[0]) begin
            seen = 1;
            clr[0] = 1'b0;
            n_cmp++;
            if (btn_pending[0] !== 1'b1) begin
               n_err++;
               $display("FAIL pend_collision got=%b exp=1", btn_pending[0]);
            end
         end
      end
      clr[0] = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL pend_press_seen got=0 exp=1");
      end
      step();
      step();
      clr[0] = 1'b1;
      step();
      clr[0] = 1'b0;
      n_cmp++;
      if (btn_pending[0] !== 1'b0 || btn_pending[4] !== 1'b1) begin
         n_err++;
         $display("FAIL pend_clear got=%b%b exp=10", btn_pending[4], btn_pending[0]);
      end
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_pending} !==
          {mlevel, mpress, mrel, mpend}) begin
         n_err++;
         $display("FAIL pend_model got=%h exp=%h",
                  {btn_level, btn_press, btn_release, btn_pending},
                  {mlevel, mpress, mrel, mpend});
      end
   endtask

   task automatic test_independence();
      int p0, p3, rise, np;
      reset = 1'b1;
      btn_raw = '0;
      clr = '0;
      step();
      reset = 1'b0;
      p0 = -1; p3 = -1;
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k == 3) btn_raw[3] = 1'b1;
         step();
         if (btn_press[0]) p0 = k;
         if (btn_press[3]) p3 = k;
      end
      n_cmp++;
      if (p0 !== 6 || p3 !== 8) begin
         n_err++;
         $display("FAIL indep_press_edges got=%0d/%0d exp=6/8", p0, p3);
      end
      btn_raw = '0;
      for (int k = 0; k < 12; k++) step();
      btn_raw[3] = 1'b1;
      for (int k = 0; k < 4; k++) step();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         n_cmp++;
         if (btn_press !== '0 || btn_level !== '0) begin
            n_err++;
            $display("FAIL indep_reset got=%b/%b exp=0/0", btn_press, btn_level);
         end
      end
      reset = 1'b0;
      rise = -1;
      np = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !==
             {mlevel, mpress, mrel, mpend}) begin
            n_err++;
            $display("FAIL indep_model got=%h exp=%h",
                     {btn_level, btn_press, btn_release, btn_pending},
                     {mlevel, mpress, mrel, mpend});
         end
         if (btn_level[3] && rise < 0) rise = k;
         if (btn_press[3]) np++;
      end
      n_cmp++;
      if (rise !== 6 || np !== 1) begin
         n_err++;
         $display("FAIL indep_restart got=%0d/%0d exp=6/1", rise, np);
      end
   endtask

   task automatic test_random();
      logic [NB-1:0] prev_p, prev_r;
      prev_p = '0;
      prev_r = '0;
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 6) == 0) btn_raw[i] = ~btn_raw[i];
            clr[i] = ($urandom_range(0, 9) == 0);
         end
         step();
         n_cmp++;
         if ({btn_level, btn_press, btn_release, btn_pending} !==
             {mlevel, mpress, mrel, mpend}) begin
            n_err++;
            $display("FAIL rand_model k=%0d got=%h exp=%h", k,
                     {btn_level, btn_press, btn_release, btn_pending},
                     {mlevel, mpress, mrel, mpend});
         end
         n_cmp++;
         if (((btn_press & btn_release) | (btn_press & prev_p) |
              (btn_release & prev_r)) !== '0) begin
            n_err++;
            $display("FAIL rand_pulse_rule k=%0d got=%b/%b exp=exclusive single",
                     k, btn_press, btn_release);
         end
         prev_p = btn_press;
         prev_r = btn_release;
      end
      reset = 1'b0;
      clr = '0;
   endtask

   initial begin
      for (int i = 0; i < NB; i++) begin
         hw[i] = '0;
         hn[i] = 0;
      end
      test_reset();
      test_press_release();
      test_bounce();
      test_glitch();
      test_pending_clear();
      test_independence();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
- Upstream stage for the button controller peripheral. Turns raw, asynchronous, bouncy push-button pins into clean signals.
- Per button it provides a synchronized, debounced level, single-cycle press and release pulses, and a sticky "pressed" flag.
- The sticky flag is held until the consumer clears it.
- btn_pending[0] (or btn_level[0]) drives the controller's in[0] bit, so the controller sees one clean event per physical press.

Parameters:
- NUM_BTNS, 5, number of independent button channels (1..16).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required before a level change is accepted. Must be >= 2. Counter width = clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTNS  raw button pins, asynchronous to clk, active-high.
- clr  in  NUM_BTNS  per-bit clear of btn_pending, sampled each cycle.
- btn_level  out  NUM_BTNS  debounced button level.
- btn_press  out  NUM_BTNS  one-cycle pulse on an accepted 0->1 of btn_level.
- btn_release  out  NUM_BTNS  one-cycle pulse on an accepted 1->0 of btn_level.
- btn_pending  out  NUM_BTNS  sticky press flag, set by btn_press, cleared by clr.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset effects, all channels, on the clk edge where reset=1:
  - both synchronizer flops cleared to 0;
  - FSM returns to LOW and the counter clears to 0;
  - btn_level, btn_press, btn_release and btn_pending all read 0.
- Reset mid-bounce or mid-count discards all progress. A button held high through reset is re-debounced from the first edge after reset deasserts, and produces a normal btn_press.
- Synchronizer: a 2-flop chain per channel, s1 <= btn_raw and s2 <= s1. The FSM uses only s2.
- Per-channel FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. btn_level = 1 in HIGH and FALL_WAIT, 0 otherwise.
  - LOW: if s2=1, go to RISE_WAIT with cnt=1; otherwise stay, cnt=0.
  - RISE_WAIT: if s2=0, go to LOW with cnt=0 (bounce rejected). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to HIGH with cnt=0 and assert btn_press for exactly the next cycle. Otherwise cnt<=cnt+1.
  - HIGH and FALL_WAIT: mirror images of LOW and RISE_WAIT with s2 inverted. The accepted transition asserts btn_release.
- Latency: edge 1 is the first clk edge sampling a new stable btn_raw value.
  - s2 updates at edge 2.
  - btn_level changes at edge 2+DEBOUNCE_CYCLES, and btn_press/btn_release are high for the cycle following that edge.
  - Any reversion of s2 before acceptance restarts counting from 0.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is only active in the WAIT states.
- btn_press and btn_release are registered outputs. They are never both high on the same channel, and never high two cycles in a row.
- btn_pending[i]:
  - set on the edge where btn_press[i] is asserted, i.e. visible in the same cycle as btn_press;
  - cleared on an edge with clr[i]=1;
  - simultaneous set and clear: set wins (the press is not lost);
  - clr on a bit that is already 0 has no effect;
  - multiple presses before a clear leave it at 1 (no count).
- Channels are fully independent. There is no cross-channel priority.

Test Plan:
- Reset: assert reset 3 cycles with btn_raw=all ones -> all outputs 0. After deassert with DEBOUNCE_CYCLES=4, btn_level[0] goes to 1 at edge 6 after deassert and btn_press[0] pulses once.
- Clean press/release, D=4: btn_raw[0] 0->1 held 20 cycles, then 1->0 held 20 cycles ->
  - btn_level[0] rises exactly 6 edges after first sampling, with one btn_press pulse;
  - btn_level[0] falls 6 edges after the release, with one btn_release pulse;
  - btn_pending[0]=1 from the press onward.
- Bounce rejection, D=4: btn_raw[1] toggles 1,1,0,1,0,1 (one cycle each), then holds 1 -> no output change during the toggles. btn_level[1] rises 6 edges after the final stable 1; exactly one btn_press.
- Glitch shorter than D: btn_raw[2]=1 for 3 cycles, then 0 -> btn_level[2], btn_press[2] and btn_pending[2] stay 0 throughout.
- Pending clear collision: hold clr[0]=1 on the same edge that sets btn_pending[0] -> btn_pending[0] reads 1. A later single-cycle clr[0] pulse -> btn_pending[0] reads 0 next cycle, and other bits are unchanged.
- Independence plus reset mid-count: press buttons 0 and 3 staggered by 2 cycles -> press pulses 2 cycles apart. Assert reset while channel 3 is in RISE_WAIT -> channel 3 restarts, with no spurious btn_press during or at reset.
